// File: rtl/seq_shifter_if.sv
// rtl/seq_shifter_if.sv - start/result handshake bundle for the multi-cycle shifter
interface seq_shifter_if #(
    parameter int WIDTH = 16
) ();
    localparam int AMT_W = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [AMT_W-1:0] amt;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] outShift;
    logic             overflow;

    modport master (
        output start, a, amt, mode,
        input  busy, done, outShift, overflow
    );

    modport slave (
        input  start, a, amt, mode,
        output busy, done, outShift, overflow
    );
endinterface

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - one-bit-per-clock shifter with SLL/SRL/SRA/ROL modes and lost-bit flag
module seq_shifter #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    seq_shifter_if.slave   bus
);
    localparam int AMT_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_SLL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;

        case (state_q)
            SHIFT: begin
                case (mode_q)
                    MODE_SLL: begin
                        out_d = {out_q[WIDTH-2:0], 1'b0};
                        ovf_d = ovf_q | out_q[WIDTH-1];
                    end
                    MODE_SRL: begin
                        out_d = {1'b0, out_q[WIDTH-1:1]};
                        ovf_d = ovf_q | out_q[0];
                    end
                    MODE_SRA: begin
                        out_d = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                        ovf_d = ovf_q | out_q[0];
                    end
                    default: begin
                        out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                    end
                endcase
                cnt_d = cnt_q - AMT_W'(1);
                // cnt_q==1 means this shift is the last one
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation
                if (bus.start) begin
                    out_d   = bus.a;
                    cnt_d   = bus.amt;
                    mode_d  = bus.mode;
                    ovf_d   = 1'b0;
                    state_d = (bus.amt == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.outShift = out_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed checks of seq_shifter at WIDTH=16 and WIDTH=8
module tb_seq_shifter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_shifter_if #(.WIDTH(16)) b16 ();
    seq_shifter_if #(.WIDTH(8))  b8  ();

    seq_shifter #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
    seq_shifter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

    int passed = 0;
    int total  = 0;
    bit sel = 1'b0;

    logic        o_busy, o_done, o_ovf;
    logic [15:0] o_out;
    assign o_busy = sel ? b8.busy     : b16.busy;
    assign o_done = sel ? b8.done     : b16.done;
    assign o_ovf  = sel ? b8.overflow : b16.overflow;
    assign o_out  = sel ? {8'h00, b8.outShift} : b16.outShift;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s w%0d observed=%0h expected=%0h", tag, sel ? 8 : 16, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [1:0] m, input logic [15:0] av, input int amt);
        if (sel) begin
            b8.start = s; b8.mode = m; b8.a = av[7:0]; b8.amt = 3'(amt);
        end else begin
            b16.start = s; b16.mode = m; b16.a = av; b16.amt = 4'(amt);
        end
    endtask

    task automatic start_op(input logic [1:0] m, input logic [15:0] av, input int amt);
        drive(1'b1, m, av, amt);
        step();
        drive(1'b0, 2'b11, 16'hDEAD, 0);
    endtask

    // Counts cycles since the start edge until done, bounded
    task automatic wait_done(input int cyc_in, output int cyc, output int bcnt);
        cyc  = cyc_in;
        bcnt = 0;
        while (!o_done && cyc < 64) begin
            if (o_busy) bcnt++;
            step();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] av,
                          input int amt, input logic [15:0] eo, input logic ev);
        int cyc, bcnt;
        start_op(m, av, amt);
        wait_done(1, cyc, bcnt);
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(amt + 1));
        chk({tag, "_busycyc"}, 32'(bcnt), 32'(amt));
        chk({tag, "_out"}, 32'(o_out), 32'(eo));
        chk({tag, "_ovf"}, 32'(o_ovf), 32'(ev));
        step();
        chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        chk({tag, "_hold"}, 32'(o_out), 32'(eo));
    endtask

    initial begin
        int cyc, bcnt, dcnt;
        sel = 1'b0; drive(1'b0, 2'b00, 16'h0, 0);
        sel = 1'b1; drive(1'b0, 2'b00, 16'h0, 0);
        step(); step();
        rst = 1'b0;

        for (int w = 0; w < 2; w++) begin
            sel = (w == 1);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_done", 32'(o_done), 32'd0);
            chk("rst_out",  32'(o_out),  32'd0);
            chk("rst_ovf",  32'(o_ovf),  32'd0);
        end

        sel = 1'b0;
        run_op("sll16",  2'b00, 16'h4001, 2,  16'h0004, 1'b1);
        run_op("sra16",  2'b10, 16'h8010, 4,  16'hF801, 1'b0);
        run_op("srl16",  2'b01, 16'h000F, 3,  16'h0001, 1'b1);
        run_op("rol16",  2'b11, 16'h8001, 1,  16'h0003, 1'b0);
        run_op("zero16", 2'b10, 16'h1234, 0,  16'h1234, 1'b0);
        run_op("sramax", 2'b10, 16'h8000, 15, 16'hFFFF, 1'b0);
        run_op("rolmax", 2'b11, 16'h8001, 15, 16'hC000, 1'b0);

        // Start during SHIFT is ignored; start in DONE is taken
        start_op(2'b00, 16'h0001, 5);
        step();
        drive(1'b1, 2'b11, 16'hFFFF, 1);
        step();
        drive(1'b0, 2'b00, 16'h0, 0);
        wait_done(3, cyc, bcnt);
        chk("ign_done", 32'(o_done), 32'd1);
        chk("ign_lat",  32'(cyc), 32'd6);
        chk("ign_out",  32'(o_out), 32'h0020);
        chk("ign_ovf",  32'(o_ovf), 32'd0);
        start_op(2'b11, 16'h00FF, 4);
        wait_done(1, cyc, bcnt);
        chk("b2b_done", 32'(o_done), 32'd1);
        chk("b2b_lat",  32'(cyc), 32'd5);
        chk("b2b_out",  32'(o_out), 32'h0FF0);
        step();

        // Mid-operation reset aborts without a done pulse
        start_op(2'b01, 16'hFFFF, 10);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_out",  32'(o_out),  32'd0);
        chk("abort_ovf",  32'(o_ovf),  32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (o_done || o_busy) dcnt++;
            step();
        end
        chk("abort_quiet", 32'(dcnt), 32'd0);
        run_op("post_rst", 2'b01, 16'h000F, 3, 16'h0001, 1'b1);

        sel = 1'b1;
        run_op("sll8",  2'b00, 16'h0081, 1, 16'h0002, 1'b1);
        run_op("sra8",  2'b10, 16'h0090, 4, 16'h00F9, 1'b0);
        run_op("srl8",  2'b01, 16'h000F, 3, 16'h0001, 1'b1);
        run_op("rol8",  2'b11, 16'h0081, 1, 16'h0003, 1'b0);
        run_op("zero8", 2'b00, 16'h005A, 0, 16'h005A, 1'b0);
        run_op("rol8max", 2'b11, 16'h0081, 7, 16'h00C0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
